// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and the fetch packet type used by the
// front end.
package uarch_pkg;
  localparam int CPU_ADDR_BITS      = 32;
  localparam int CPU_INST_BITS      = 32;
  localparam int PIPE_WIDTH         = 2;
  localparam int IBUF_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts;
  } fetch_packet_t;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous circular FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. Entry storage is intentionally not reset.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq,
  output logic [WIDTH-1:0]         deq_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Flush discards everything, including a same-cycle enq/deq.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      if (enq && !deq) begin
        count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) mem_q[tail_q] <= enq_data;
  end

  assign deq_data = mem_q[head_q];
  assign count    = count_q;
endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: whole-packet FIFO with valid/ready
// handshakes. Define INST_BUF_BYPASS_EN to forward a packet straight to decode when empty.
module inst_buffer
  import uarch_pkg::*;
#(
  parameter int IBUF_DEPTH = IBUF_DEPTH_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] fetch_pcs,
  input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] fetch_insts,
  input  logic                                   fetch_pkt_val,
  output logic                                   ibuf_rdy,
  input  logic                                   decode_rdy,
  output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs,
  output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts,
  output logic                                   fetch_val,
  output logic [$clog2(IBUF_DEPTH):0]            ibuf_count
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(IBUF_DEPTH);

  fetch_packet_t enq_pkt_s, head_pkt_s;
  logic          enq_s, deq_s, empty_s;
  logic [CW-1:0] count_s;

  assign enq_pkt_s.pcs   = fetch_pcs;
  assign enq_pkt_s.insts = fetch_insts;
  assign empty_s         = (count_s == '0);
  assign ibuf_rdy        = (count_s != FULL_CNT);
  assign ibuf_count      = count_s;
  assign deq_s           = !empty_s && decode_rdy && !flush;

`ifdef INST_BUF_BYPASS_EN
  logic bypass_s;
  assign bypass_s  = empty_s && fetch_pkt_val && !flush;
  // A bypassed packet taken by decode in the same cycle never touches storage.
  assign enq_s     = fetch_pkt_val && ibuf_rdy && !flush && !(bypass_s && decode_rdy);
  assign fetch_val = !empty_s || bypass_s;
  assign inst_pcs  = empty_s ? fetch_pcs   : head_pkt_s.pcs;
  assign insts     = empty_s ? fetch_insts : head_pkt_s.insts;
`else
  assign enq_s     = fetch_pkt_val && ibuf_rdy && !flush;
  assign fetch_val = !empty_s;
  assign inst_pcs  = head_pkt_s.pcs;
  assign insts     = head_pkt_s.insts;
`endif

  fifo_sync #(
    .WIDTH ($bits(fetch_packet_t)),
    .DEPTH (IBUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .enq      (enq_s),
    .enq_data (enq_pkt_s),
    .deq      (deq_s),
    .deq_data (head_pkt_s),
    .count    (count_s)
  );
endmodule
